// File: rtl/lc3b_types.sv
// Shared LC-3b cache types: L2 line/tag widths and the writeback drain states.
package lc3b_types;
  localparam int L2_LINE_W   = 128;
  localparam int L2_ADDR_W   = 16;
  localparam int L2_OFFSET_W = 4;

  typedef logic [L2_LINE_W-1:0]             lc3b_l2line;
  typedef logic [L2_ADDR_W-L2_OFFSET_W-1:0] lc3b_l2tag;

  typedef enum logic {
    WB_IDLE  = 1'b0,
    WB_WRITE = 1'b1
  } wb_state_e;
endpackage

// File: rtl/l2_writeback_buffer_if.sv
// Eviction, lookup and pmem write signals of the L2 writeback buffer.
interface l2_writeback_buffer_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              evict_valid;
  logic [ADDR_W-1:0] evict_addr;
  logic [LINE_W-1:0] evict_data;
  logic              evict_ready;
  logic [ADDR_W-1:0] lookup_addr;
  logic              lookup_hit;
  logic [LINE_W-1:0] lookup_data;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_resp;
  logic              wb_empty;
  logic [CNT_W-1:0]  wb_count;

  // The buffer itself.
  modport slave (
    input  evict_valid, evict_addr, evict_data, lookup_addr, pmem_resp,
    output evict_ready, lookup_hit, lookup_data,
    output pmem_write, pmem_address, pmem_wdata, wb_empty, wb_count
  );

  // L2 controller plus physical memory.
  modport master (
    output evict_valid, evict_addr, evict_data, lookup_addr, pmem_resp,
    input  evict_ready, lookup_hit, lookup_data,
    input  pmem_write, pmem_address, pmem_wdata, wb_empty, wb_count
  );
endinterface

// File: rtl/l2_wb_match.sv
// Priority matcher: flags a tag hit and one-hot selects the youngest matching entry.
module l2_wb_match #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 12,
  parameter int AGE_W = 2
) (
  input  logic [DEPTH-1:0] valid,
  input  logic [TAG_W-1:0] tag [DEPTH],
  input  logic [AGE_W-1:0] age [DEPTH],
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  output logic [DEPTH-1:0] sel
);
  logic [DEPTH-1:0] match;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic beaten;

      assign match[gi] = valid[gi] && (tag[gi] == lookup_tag);

      // Valid entries have distinct ages, so exactly one match survives.
      always_comb begin
        beaten = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
          if (j != gi && match[j] && (age[j] > age[gi])) begin
            beaten = 1'b1;
          end
        end
      end

      assign sel[gi] = match[gi] && !beaten;
    end
  endgenerate

  assign hit = |match;
endmodule

// File: rtl/l2_writeback_buffer.sv
// FIFO of dirty L2 victim lines drained to pmem one write at a time.
// Define L2_WB_FORWARD_EN to build the same-address lookup forwarding path.
module l2_writeback_buffer
  import lc3b_types::*;
#(
  parameter int DEPTH    = 4,
  parameter int LINE_W   = $bits(lc3b_l2line),
  parameter int ADDR_W   = L2_ADDR_W,
  parameter int OFFSET_W = L2_OFFSET_W
) (
  input  logic                 clk,
  input  logic                 rst,
  l2_writeback_buffer_if.slave wb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = ADDR_W - OFFSET_W;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [TAG_W-1:0]  tag_reg  [DEPTH];
  logic [LINE_W-1:0] data_reg [DEPTH];
  logic [DEPTH-1:0]  valid_reg;
  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [ADDR_W-1:0] pmem_address_reg;
  logic [LINE_W-1:0] pmem_wdata_reg;
  wb_state_e         state_reg;
  wb_state_e         state_next;

  logic push;
  logic pop;
  logic load;
  logic unused_bits;

  // A slot freed by a pop only becomes usable on the following cycle.
  assign push = wb.evict_valid && (count_reg != FULL_COUNT);

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    load       = 1'b0;
    case (state_reg)
      WB_IDLE: begin
        if (count_reg != '0) begin
          state_next = WB_WRITE;
          load       = 1'b1;
        end
      end
      WB_WRITE: begin
        if (wb.pmem_resp) begin
          state_next = WB_IDLE;
          pop        = 1'b1;
        end
      end
      default: state_next = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= WB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Line storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_reg[tail_reg]  <= wb.evict_addr[ADDR_W-1:OFFSET_W];
      data_reg[tail_reg] <= wb.evict_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg        <= '0;
      head_reg         <= '0;
      tail_reg         <= '0;
      count_reg        <= '0;
      pmem_address_reg <= '0;
      pmem_wdata_reg   <= '0;
    end else begin
      if (pop) begin
        valid_reg[head_reg] <= 1'b0;
        head_reg            <= head_reg + PTR_W'(1);
      end
      if (push) begin
        valid_reg[tail_reg] <= 1'b1;
        tail_reg            <= tail_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      if (load) begin
        pmem_address_reg <= {tag_reg[head_reg], {OFFSET_W{1'b0}}};
        pmem_wdata_reg   <= data_reg[head_reg];
      end
    end
  end

  assign wb.pmem_write   = (state_reg == WB_WRITE);
  assign wb.pmem_address = pmem_address_reg;
  assign wb.pmem_wdata   = pmem_wdata_reg;
  assign wb.evict_ready  = (count_reg != FULL_COUNT);
  assign wb.wb_empty     = (count_reg == '0);
  assign wb.wb_count     = count_reg;

`ifdef L2_WB_FORWARD_EN
  logic [PTR_W-1:0]  age [DEPTH];
  logic [DEPTH-1:0]  sel;
  logic              fwd_hit;
  logic [LINE_W-1:0] fwd_data;

  // Age counts from head, so the entry closest behind tail is the largest.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
      assign age[gi] = PTR_W'(gi) - head_reg;
    end
  endgenerate

  l2_wb_match #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .AGE_W (PTR_W)
  ) u_match (
    .valid      (valid_reg),
    .tag        (tag_reg),
    .age        (age),
    .lookup_tag (wb.lookup_addr[ADDR_W-1:OFFSET_W]),
    .hit        (fwd_hit),
    .sel        (sel)
  );

  always_comb begin
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        fwd_data = fwd_data | data_reg[i];
      end
    end
  end

  assign wb.lookup_hit  = fwd_hit;
  assign wb.lookup_data = fwd_data;
  assign unused_bits    = ^{wb.evict_addr[OFFSET_W-1:0], wb.lookup_addr[OFFSET_W-1:0]};
`else
  assign wb.lookup_hit  = 1'b0;
  assign wb.lookup_data = '0;
  assign unused_bits    = ^{wb.evict_addr[OFFSET_W-1:0], wb.lookup_addr};
`endif
endmodule

// File: tb/tb_l2_writeback_buffer.sv
// Self-checking bench for l2_writeback_buffer: vector table, corner sequences, random vs queue model.
module tb_l2_writeback_buffer;
  import lc3b_types::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  l2_writeback_buffer_if #(.ADDR_W(L2_ADDR_W), .LINE_W(L2_LINE_W), .DEPTH(DEPTH)) bus ();

  l2_writeback_buffer #(
    .DEPTH    (DEPTH),
    .LINE_W   (L2_LINE_W),
    .ADDR_W   (L2_ADDR_W),
    .OFFSET_W (L2_OFFSET_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        ev;
    logic [15:0] addr;
    logic        resp;
    logic [2:0]  cnt;
    logic        wr;
    logic        rdy;
    logic [15:0] waddr;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, want);
  endtask

  function automatic bit fwd_on();
`ifdef L2_WB_FORWARD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic lc3b_l2line pat(input logic [15:0] a);
    return {8{a}};
  endfunction

  function automatic lc3b_l2tag tag_of(input logic [15:0] a);
    return a[15:4];
  endfunction

  task automatic idle_inputs();
    bus.evict_valid = 1'b0;
    bus.evict_addr  = '0;
    bus.evict_data  = '0;
    bus.pmem_resp   = 1'b0;
    bus.lookup_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; presents one line for exactly one rising edge.
  task automatic enqueue(input logic [15:0] a, input lc3b_l2line d);
    bus.evict_valid = 1'b1;
    bus.evict_addr  = a;
    bus.evict_data  = d;
    @(negedge clk);
    bus.evict_valid = 1'b0;
  endtask

  task automatic flush(input string name);
    int guard = 0;
    while (!(bus.wb_empty === 1'b1 && bus.pmem_write === 1'b0) && guard < 64) begin
      bus.pmem_resp = bus.pmem_write;
      @(negedge clk);
      guard++;
    end
    bus.pmem_resp = 1'b0;
    check(name, 128'(bus.wb_empty), 128'(1));
  endtask

  task automatic check_state(input string name, input int cnt, input logic wr);
    check({name, "_count"}, 128'(bus.wb_count), 128'(cnt));
    check({name, "_write"}, 128'(bus.pmem_write), 128'(wr));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] q_addr [$];
    lc3b_l2line  q_data [$];
    bit          exp_write;
    lc3b_l2line  d1, d2;

    tbl[0]  = '{1'b1, 16'h0010, 1'b0, 3'd1, 1'b0, 1'b1, 16'h0000};
    tbl[1]  = '{1'b1, 16'h0020, 1'b0, 3'd2, 1'b1, 1'b1, 16'h0010};
    tbl[2]  = '{1'b1, 16'h0030, 1'b0, 3'd3, 1'b1, 1'b1, 16'h0010};
    tbl[3]  = '{1'b1, 16'h0040, 1'b0, 3'd4, 1'b1, 1'b0, 16'h0010};
    tbl[4]  = '{1'b1, 16'h0050, 1'b0, 3'd4, 1'b1, 1'b0, 16'h0010};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 3'd3, 1'b0, 1'b1, 16'h0000};
    tbl[6]  = '{1'b0, 16'h0000, 1'b0, 3'd3, 1'b1, 1'b1, 16'h0020};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 3'd2, 1'b0, 1'b1, 16'h0000};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, 3'd2, 1'b1, 1'b1, 16'h0030};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 3'd1, 1'b0, 1'b1, 16'h0000};
    tbl[10] = '{1'b0, 16'h0000, 1'b0, 3'd1, 1'b1, 1'b1, 16'h0040};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 3'd0, 1'b0, 1'b1, 16'h0000};
    tbl[12] = '{1'b0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b1, 16'h0000};

    // Reset state
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 128'(bus.evict_ready), 128'(1));
    check("rst_empty", 128'(bus.wb_empty), 128'(1));
    check("rst_count", 128'(bus.wb_count), 128'(0));
    check("rst_write", 128'(bus.pmem_write), 128'(0));
    check("rst_addr", 128'(bus.pmem_address), 128'(0));
    check("rst_wdata", bus.pmem_wdata, 128'(0));
    check("rst_hit", 128'(bus.lookup_hit), 128'(0));
    check("rst_ldata", bus.lookup_data, 128'(0));
    rst = 1'b0;
    @(negedge clk);
    check_state("post_rst", 0, 1'b0);

    // Single drain with a three-cycle memory response
    do_reset();
    enqueue(16'h1234, {16{8'hA5}});
    check_state("t1_latency", 1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("t1_write_c%0d", c), 128'(bus.pmem_write), 128'(1));
      check($sformatf("t1_addr_c%0d", c), 128'(bus.pmem_address), 128'(16'h1230));
      check($sformatf("t1_data_c%0d", c), bus.pmem_wdata, {16{8'hA5}});
    end
    bus.pmem_resp = 1'b1;
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    check_state("t1_done", 0, 1'b0);
    check("t1_empty", 128'(bus.wb_empty), 128'(1));

    // Fill to full, drop the extra line, drain in order
    do_reset();
    for (int i = 0; i < 13; i++) begin
      bus.evict_valid = tbl[i].ev;
      bus.evict_addr  = tbl[i].addr;
      bus.evict_data  = pat(tbl[i].addr);
      bus.pmem_resp   = tbl[i].resp;
      @(negedge clk);
      check($sformatf("vec%0d_count", i), 128'(bus.wb_count), 128'(tbl[i].cnt));
      check($sformatf("vec%0d_write", i), 128'(bus.pmem_write), 128'(tbl[i].wr));
      check($sformatf("vec%0d_ready", i), 128'(bus.evict_ready), 128'(tbl[i].rdy));
      if (tbl[i].wr) begin
        check($sformatf("vec%0d_addr", i), 128'(bus.pmem_address), 128'(tbl[i].waddr));
        check($sformatf("vec%0d_data", i), bus.pmem_wdata, pat(tbl[i].waddr));
      end
    end
    idle_inputs();

    // Simultaneous enqueue and pop at count=2
    do_reset();
    enqueue(16'h0300, pat(16'h0300));
    enqueue(16'h0310, pat(16'h0310));
    check_state("t3_pre", 2, 1'b1);
    bus.evict_valid = 1'b1;
    bus.evict_addr  = 16'h0320;
    bus.evict_data  = pat(16'h0320);
    bus.pmem_resp   = 1'b1;
    @(negedge clk);
    idle_inputs();
    check_state("t3_both", 2, 1'b0);
    @(negedge clk);
    check("t3_next_addr", 128'(bus.pmem_address), 128'(16'h0310));
    check("t3_next_write", 128'(bus.pmem_write), 128'(1));
    flush("t3_flush");

    // Forwarding of the youngest duplicate
    do_reset();
    d1 = {4{32'hD1D1_0001}};
    d2 = {4{32'hD2D2_0002}};
    enqueue(16'h0100, d1);
    bus.lookup_addr = 16'h0108;
    bus.evict_valid = 1'b1;
    bus.evict_addr  = 16'h0100;
    bus.evict_data  = d2;
    #1;
    check("t4_same_cycle_data", bus.lookup_data, fwd_on() ? d1 : '0);
    @(negedge clk);
    bus.evict_valid = 1'b0;
    #1;
    check("t4_hit", 128'(bus.lookup_hit), 128'(fwd_on()));
    check("t4_data", bus.lookup_data, fwd_on() ? d2 : '0);
    bus.lookup_addr = 16'h0200;
    #1;
    check("t4_miss_hit", 128'(bus.lookup_hit), 128'(0));
    check("t4_miss_data", bus.lookup_data, 128'(0));
    @(negedge clk);
    flush("t4_flush");

    // Asynchronous reset in the middle of a write
    do_reset();
    enqueue(16'h0400, pat(16'h0400));
    enqueue(16'h0410, pat(16'h0410));
    enqueue(16'h0420, pat(16'h0420));
    check_state("t5_pre", 3, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_state("t5_async", 0, 1'b0);
    check("t5_empty", 128'(bus.wb_empty), 128'(1));
    @(negedge clk);
    rst = 1'b0;
    bus.pmem_resp = 1'b1;
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    check_state("t5_late_resp", 0, 1'b0);
    @(negedge clk);
    check_state("t5_after", 0, 1'b0);

    // Back-to-back drain shows exactly one idle bubble
    do_reset();
    enqueue(16'h0500, pat(16'h0500));
    enqueue(16'h0510, pat(16'h0510));
    check("t6_first_addr", 128'(bus.pmem_address), 128'(16'h0500));
    bus.pmem_resp = 1'b1;
    @(negedge clk);
    check_state("t6_bubble", 1, 1'b0);
    @(negedge clk);
    check_state("t6_second", 1, 1'b1);
    check("t6_second_addr", 128'(bus.pmem_address), 128'(16'h0510));
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    check_state("t6_done", 0, 1'b0);

    // Random traffic against a FIFO-of-lines reference
    do_reset();
    exp_write = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit          exp_hit;
      lc3b_l2line  exp_ld;
      bit          ev, rsp, accept, popped;
      int          n;
      logic [15:0] a;
      lc3b_l2line  d;

      bus.lookup_addr = 16'(($urandom_range(1, 7) << 8) | $urandom_range(0, 15));
      #1;
      exp_hit = 1'b0;
      exp_ld  = '0;
      for (int i = q_addr.size() - 1; i >= 0; i--) begin
        if (tag_of(q_addr[i]) == tag_of(bus.lookup_addr)) begin
          exp_hit = 1'b1;
          exp_ld  = q_data[i];
          break;
        end
      end
      if (!fwd_on()) begin
        exp_hit = 1'b0;
        exp_ld  = '0;
      end
      check($sformatf("rnd%0d_hit", cyc), 128'(bus.lookup_hit), 128'(exp_hit));
      check($sformatf("rnd%0d_ldata", cyc), bus.lookup_data, exp_ld);
      check($sformatf("rnd%0d_count", cyc), 128'(bus.wb_count), 128'(q_addr.size()));
      check($sformatf("rnd%0d_ready", cyc), 128'(bus.evict_ready), 128'(q_addr.size() < DEPTH));
      check($sformatf("rnd%0d_write", cyc), 128'(bus.pmem_write), 128'(exp_write));
      if (exp_write) begin
        check($sformatf("rnd%0d_addr", cyc), 128'(bus.pmem_address), 128'(q_addr[0]));
        check($sformatf("rnd%0d_data", cyc), bus.pmem_wdata, q_data[0]);
      end

      ev  = ($urandom_range(0, 9) < 6);
      rsp = ($urandom_range(0, 9) < 4);
      a   = 16'(($urandom_range(1, 6) << 8) | $urandom_range(0, 15));
      d   = {$urandom, $urandom, $urandom, $urandom};
      bus.evict_valid = ev;
      bus.evict_addr  = a;
      bus.evict_data  = d;
      bus.pmem_resp   = rsp;

      n      = q_addr.size();
      accept = ev && (n < DEPTH);
      popped = exp_write && rsp;
      if (popped) begin
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
      end
      if (accept) begin
        q_addr.push_back(a & 16'hFFF0);
        q_data.push_back(d);
      end
      exp_write = exp_write ? !rsp : (n > 0);
      @(negedge clk);
    end
    idle_inputs();
    flush("rnd_flush");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
